timebase_ctrl: RTL and testbench
================================

# timebase_ctrl

Run-time controller for the board timebase: one shared half-period counter clocked from the 50 MHz oscillator that produces a 50 %-duty square wave and a one-cycle tick enable per half period. Adds start/stop sequencing and a valid/ready configuration port. A new period is applied only at a half-period boundary, so the output never glitches. Sits between the control logic (buttons, mode FSMs) and every block that consumes slow ticks (display scan, LED blink, seconds counter).

## Interface
- `CNT_W`, 25: width of the half-period counter and configuration value.
- `DEFAULT_HALF`, 25'd24_999_999: half-period terminal count loaded at reset (1 Hz at 50 MHz).

- `clk` in 1: 50 MHz board clock; the only clock.
- `clr` in 1: reset; synchronous and active-high.
- `start` in 1: level-sampled; begin counting from IDLE.
- `stop` in 1: level-sampled; return to IDLE.
- `cfg_valid` in 1: new half-period value offered.
- `cfg_half` in CNT_W: terminal count; half period = cfg_half+1 cycles.
- `cfg_ready` out 1: configuration can be accepted this cycle.
- `tick` out 1: one-cycle pulse at every half-period wrap.
- `sq_out` out 1: 50 % duty square wave, period 2·(half+1) cycles.
- `busy` out 1: high in RUN or PEND.

## Operation
- Reset (`clr`=1 at an edge, overrides all inputs) sets: state IDLE, cnt=0, half_reg=DEFAULT_HALF, pend_reg=0, sq_out=0, tick=0, busy=0, cfg_ready=1.
- States: IDLE, RUN, PEND (new value waiting for a boundary).
- IDLE behaviour:
  - cnt is held at 0, sq_out at 0 and tick at 0.
  - `start` moves to RUN.
  - A cfg handshake (cfg_valid & cfg_ready) writes half_reg directly.
- RUN behaviour:
  - cnt increments each cycle.
  - When cnt==half_reg, the wrap fires: cnt<=0, sq_out<=~sq_out, tick<=1. Otherwise tick<=0.
  - A cfg handshake stores cfg_half in pend_reg and moves to PEND.
- PEND behaviour:
  - Counts as in RUN, with cfg_ready=0.
  - At the next wrap: half_reg<=pend_reg and state goes to RUN. That wrap itself still uses the old half_reg.
- `stop` in RUN or PEND moves to IDLE:
  - cnt<=0, sq_out<=0, tick<=0.
  - A pending value is committed to half_reg, not discarded.
- Handshake rules:
  - cfg_ready = (state != PEND), combinational from state only.
  - A transfer occurs only when cfg_valid & cfg_ready are both high at a clock edge.
  - cfg_valid is ignored while cfg_ready=0.
- Boundary conditions:
  - `start` and `stop` together: stop wins.
  - `start` while busy: ignored.
  - cfg accepted in the same cycle as a wrap in RUN: the wrap uses the old value, and the new value applies at the following wrap.
  - cfg_half=0 is legal: sq_out toggles every cycle and tick stays high continuously.
  - cnt never exceeds half_reg, so no overflow is possible.
  - `clr` mid-operation: the next cycle shows reset values and pending data is lost.

## Timing
- All outputs are registered except cfg_ready.
- Start latency:
  - Edge E0 samples `start`; busy=1 and cnt=0 after E0.
  - The first tick and sq_out rise appear after edge E(half+1).
- Tick spacing: ticks recur every half+1 cycles. tick is high in exactly the cycle in which sq_out shows its new value.
- Stop latency: after the edge that samples `stop`, busy=0 and sq_out=0.
- Reconfiguration latency: a new value takes effect at the first wrap after the edge that accepts it. Worst case is old_half+1 cycles.

## Structure
- Package `timebase_pkg` holds:
  - `CNT_W`, `DEFAULT_HALF`, and a `HALF_1HZ`/`HALF_1KHZ` constant pair.
  - The state enum `tb_state_t` (IDLE, RUN, PEND).
- Sub-module `half_period_counter` (enable, sync clear, terminal value in; cnt, wrap out) holds the compare/reset counter.
- `timebase_ctrl` holds the FSM, half_reg/pend_reg, sq_out and tick registers.

## Test plan
- Reset, then wait 20 cycles with start=0 → sq_out=0, tick=0, busy=0, cfg_ready=1 throughout.
- In IDLE, load cfg_half=3, then pulse start at E0 → ticks after E4, E8, E12…; sq_out high E4–E7, low E8–E11; period 8 cycles.
- Running at half=3, accept cfg_half=1 in the same cycle as a wrap → cfg_ready=0 until the next wrap 4 cycles later. After that, ticks are spaced 2 cycles apart.
- start and stop asserted together while running → IDLE next cycle; sq_out=0, busy=0. Then start alone → restarts with cnt=0.
- cfg_half=0 then start → sq_out alternates 1,0,1,… every cycle; tick is held at 1.
- Assert clr mid-PEND with a pending value of 5 → after clr: half_reg=DEFAULT_HALF, state IDLE, cfg_ready=1, pending value lost.

Source files
------------

// File: rtl/timebase_pkg.sv
// Shared constants and state encoding for the board timebase controller.
package timebase_pkg;

  localparam int unsigned CNT_W = 25;

  localparam logic [CNT_W-1:0] HALF_1HZ     = 25'd24_999_999;
  localparam logic [CNT_W-1:0] HALF_1KHZ    = 25'd24_999;
  localparam logic [CNT_W-1:0] DEFAULT_HALF = HALF_1HZ;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } tb_state_t;

endpackage

// File: rtl/half_period_counter.sv
// Half-period counter: counts 0..term while enabled, wrapping to 0 after term.
module half_period_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         sclr,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = en & (cnt == term);

  always_ff @(posedge clk) begin
    if (clr || sclr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/timebase_ctrl.sv
// Start/stop sequencing and glitch-free reconfiguration around one shared
// half-period counter that produces a square wave and a per-half-period tick.
module timebase_ctrl
  import timebase_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             tick,
  output logic             sq_out,
  output logic             busy
);

  tb_state_t        state;
  tb_state_t        state_nxt;
  logic [CNT_W-1:0] half_reg;
  logic [CNT_W-1:0] pend_reg;
  logic [CNT_W-1:0] cnt;
  logic             wrap;

  logic cnt_en;
  logic cnt_sclr;
  logic accept;
  logic load_direct;
  logic load_pend;
  logic commit_pend;

  half_period_counter #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .clr  (clr),
    .en   (cnt_en),
    .sclr (cnt_sclr),
    .term (half_reg),
    .cnt  (cnt),
    .wrap (wrap)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // stop always wins over start and over a pending wrap
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && !stop) state_nxt = RUN;
      RUN: begin
        if (stop)        state_nxt = IDLE;
        else if (accept) state_nxt = PEND;
      end
      PEND: begin
        if (stop)      state_nxt = IDLE;
        else if (wrap) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready   = (state != PEND);
    accept      = cfg_valid & cfg_ready;
    cnt_en      = (state != IDLE) & ~stop;
    cnt_sclr    = (state == IDLE) | stop;
    load_direct = accept & ((state == IDLE) | stop);
    load_pend   = accept & (state == RUN) & ~stop;
    commit_pend = (state == PEND) & (stop | wrap);
  end

  // A stop in RUN with a same-cycle handshake applies the value directly.
  always_ff @(posedge clk) begin
    if (clr) begin
      half_reg <= DEFAULT_HALF;
      pend_reg <= '0;
      tick     <= 1'b0;
      sq_out   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (load_direct)      half_reg <= cfg_half;
      else if (commit_pend) half_reg <= pend_reg;
      if (load_pend)        pend_reg <= cfg_half;
      tick   <= wrap;
      sq_out <= cnt_sclr ? 1'b0 : (sq_out ^ wrap);
      busy   <= (state_nxt != IDLE);
    end
  end

  a_cnt_bound : assert property (@(posedge clk) disable iff (clr) cnt <= half_reg);

endmodule

// File: tb/tb_timebase_ctrl.sv
// Directed self-checking bench for timebase_ctrl.
module tb_timebase_ctrl;
  import timebase_pkg::*;

  logic             clk = 1'b0;
  logic             clr;
  logic             start;
  logic             stop;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             tick;
  logic             sq_out;
  logic             busy;

  int total = 0;
  int bad   = 0;

  timebase_ctrl dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .tick      (tick),
    .sq_out    (sq_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    step();
    step();
    clr = 1'b0;
    total++;
    if (dut.half_reg !== DEFAULT_HALF) begin
      bad++; $display("FAIL reset_half got=%0d exp=%0d", dut.half_reg, DEFAULT_HALF);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if ({sq_out, tick, busy, cfg_ready} !== 4'b0001) begin
        bad++; $display("FAIL reset_idle cyc=%0d got sq/tick/busy/rdy=%b exp=0001", i,
                        {sq_out, tick, busy, cfg_ready});
      end
    end
  endtask

  // half=3: ticks after E4,E8,E12; sq high E4-E7, low E8-E11
  task automatic test_start();
    cfg_valid = 1'b1; cfg_half = 25'd3;
    step();
    cfg_valid = 1'b0;
    total++;
    if (dut.half_reg !== 25'd3 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_cfg half=%0d busy=%b exp half=3 busy=0", dut.half_reg, busy);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || dut.cnt !== '0 || tick !== 1'b0 || sq_out !== 1'b0) begin
      bad++; $display("FAIL start_e0 busy=%b cnt=%0d tick=%b sq=%b exp 1,0,0,0",
                      busy, dut.cnt, tick, sq_out);
    end
    for (int k = 1; k <= 15; k++) begin
      if (k == 6) start = 1'b1;
      if (k == 8) start = 1'b0;
      step();
      total++;
      if (tick !== ((k % 4) == 0) || sq_out !== (((k / 4) % 2) == 1) || busy !== 1'b1) begin
        bad++; $display("FAIL run_h3 k=%0d tick=%b sq=%b busy=%b exp tick=%b sq=%b busy=1",
                        k, tick, sq_out, busy, (k % 4) == 0, ((k / 4) % 2) == 1);
      end
    end
  endtask

  // cfg accepted on the E16 wrap; old half still governs until E20, then half=1
  task automatic test_reconfig();
    cfg_valid = 1'b1; cfg_half = 25'd1;
    step();
    cfg_valid = 1'b0;
    total++;
    if (tick !== 1'b1 || sq_out !== 1'b0 || cfg_ready !== 1'b0) begin
      bad++; $display("FAIL cfg_on_wrap tick=%b sq=%b rdy=%b exp 1,0,0", tick, sq_out, cfg_ready);
    end
    for (int k = 17; k <= 19; k++) begin
      if (k == 17) begin cfg_valid = 1'b1; cfg_half = 25'd7; end
      step();
      cfg_valid = 1'b0;
      total++;
      if (tick !== 1'b0 || cfg_ready !== 1'b0 || sq_out !== 1'b0) begin
        bad++; $display("FAIL pend_wait k=%0d tick=%b rdy=%b sq=%b exp 0,0,0", k, tick, cfg_ready, sq_out);
      end
    end
    step();
    total++;
    if (tick !== 1'b1 || sq_out !== 1'b1 || cfg_ready !== 1'b1 || dut.half_reg !== 25'd1) begin
      bad++; $display("FAIL pend_commit tick=%b sq=%b rdy=%b half=%0d exp 1,1,1,1",
                      tick, sq_out, cfg_ready, dut.half_reg);
    end
    for (int j = 1; j <= 6; j++) begin
      step();
      total++;
      if (tick !== ((j % 2) == 0) || sq_out !== (((j / 2) % 2) == 0)) begin
        bad++; $display("FAIL run_h1 j=%0d tick=%b sq=%b exp tick=%b sq=%b",
                        j, tick, sq_out, (j % 2) == 0, ((j / 2) % 2) == 0);
      end
    end
  endtask

  task automatic test_start_stop();
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    total++;
    if (busy !== 1'b0 || sq_out !== 1'b0 || tick !== 1'b0 || dut.state !== IDLE) begin
      bad++; $display("FAIL start_stop busy=%b sq=%b tick=%b st=%0d exp 0,0,0,IDLE",
                      busy, sq_out, tick, dut.state);
    end
    step();
    total++;
    if (busy !== 1'b0 || dut.cnt !== '0) begin
      bad++; $display("FAIL idle_hold busy=%b cnt=%0d exp 0,0", busy, dut.cnt);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || dut.cnt !== '0) begin
      bad++; $display("FAIL restart busy=%b cnt=%0d exp 1,0", busy, dut.cnt);
    end
    step();
    total++;
    if (tick !== 1'b0 || dut.cnt !== 25'd1) begin
      bad++; $display("FAIL restart_c1 tick=%b cnt=%0d exp 0,1", tick, dut.cnt);
    end
    step();
    total++;
    if (tick !== 1'b1 || sq_out !== 1'b1) begin
      bad++; $display("FAIL restart_wrap tick=%b sq=%b exp 1,1", tick, sq_out);
    end
  endtask

  task automatic test_stop_commit();
    cfg_valid = 1'b1; cfg_half = 25'd2;
    step();
    cfg_valid = 1'b0;
    total++;
    if (cfg_ready !== 1'b0 || dut.half_reg !== 25'd1) begin
      bad++; $display("FAIL stop_pend rdy=%b half=%0d exp 0,1", cfg_ready, dut.half_reg);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    total++;
    if (busy !== 1'b0 || sq_out !== 1'b0 || cfg_ready !== 1'b1 || dut.half_reg !== 25'd2) begin
      bad++; $display("FAIL stop_commit busy=%b sq=%b rdy=%b half=%0d exp 0,0,1,2",
                      busy, sq_out, cfg_ready, dut.half_reg);
    end
  endtask

  task automatic test_half_zero();
    cfg_valid = 1'b1; cfg_half = '0;
    step();
    cfg_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (tick !== 1'b0 || sq_out !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL h0_e0 tick=%b sq=%b busy=%b exp 0,0,1", tick, sq_out, busy);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      total++;
      if (tick !== 1'b1 || sq_out !== ((k % 2) == 1)) begin
        bad++; $display("FAIL h0_run k=%0d tick=%b sq=%b exp tick=1 sq=%b", k, tick, sq_out, (k % 2) == 1);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_clr_pend();
    cfg_valid = 1'b1; cfg_half = 25'd3;
    step();
    cfg_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    cfg_valid = 1'b1; cfg_half = 25'd5;
    step();
    cfg_valid = 1'b0;
    total++;
    if (cfg_ready !== 1'b0 || dut.pend_reg !== 25'd5) begin
      bad++; $display("FAIL clr_setup rdy=%b pend=%0d exp 0,5", cfg_ready, dut.pend_reg);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    total++;
    if (dut.half_reg !== DEFAULT_HALF || dut.state !== IDLE || cfg_ready !== 1'b1 ||
        dut.pend_reg !== '0 || busy !== 1'b0 || sq_out !== 1'b0 || tick !== 1'b0) begin
      bad++; $display("FAIL clr_pend half=%0d st=%0d rdy=%b pend=%0d busy=%b sq=%b tick=%b exp DEFAULT,IDLE,1,0,0,0,0",
                      dut.half_reg, dut.state, cfg_ready, dut.pend_reg, busy, sq_out, tick);
    end
    step();
    total++;
    if (busy !== 1'b0 || dut.half_reg !== DEFAULT_HALF) begin
      bad++; $display("FAIL clr_after busy=%b half=%0d exp 0,DEFAULT", busy, dut.half_reg);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_reconfig();
    test_start_stop();
    test_stop_commit();
    test_half_zero();
    test_clr_pend();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
